// File: rtl/i2c_slv_pkg.sv
// i2c_slv_pkg: shared definitions for the I2C register-file target.
//  - i2c_slv_st_t : protocol FSM states
//  - I2C_ACK/NACK : SDA level of the acknowledge bit
//  - bus_start/bus_stop : START/STOP detection from previous/current line samples
package i2c_slv_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WR,
        ST_WR_ACK,
        ST_RD,
        ST_RD_ACK,
        ST_WAIT
    } i2c_slv_st_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    // SDA falls while SCL stays high
    function automatic logic bus_start(input logic scl_p, input logic scl_c,
                                       input logic sda_p, input logic sda_c);
        return scl_p & scl_c & sda_p & ~sda_c;
    endfunction

    // SDA rises while SCL stays high
    function automatic logic bus_stop(input logic scl_p, input logic scl_c,
                                      input logic sda_p, input logic sda_c);
        return scl_p & scl_c & ~sda_p & sda_c;
    endfunction

endpackage

// File: rtl/i2c_line_filt.sv
// i2c_line_filt: 2-flop synchronizer for one I2C line, with an optional
// glitch filter (macro I2C_SLV_GLITCH_FILT_EN). With the filter, the output
// follows the synchronized value only after it has differed from the output
// for FILT_LEN consecutive clocks; shorter pulses are swallowed.
// Ports:
//  clk     in  system clock
//  resetn  in  async active-low reset (line idles high)
//  line_i  in  raw asynchronous line
//  line_o  out synchronized (and optionally filtered) line
module i2c_line_filt #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic resetn,
    input  logic line_i,
    output logic line_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], line_i};
    end

`ifdef I2C_SLV_GLITCH_FILT_EN
    localparam int CNT_W = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);

    logic [CNT_W-1:0] cnt;
    logic             filt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt    <= '0;
            filt_q <= 1'b1;
        end else if (sync_q[1] == filt_q) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(FILT_LEN - 1)) begin
            filt_q <= sync_q[1];
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign line_o = filt_q;
`else
    assign line_o = sync_q[1];
`endif

endmodule

// File: rtl/i2c_slv_regs.sv
// i2c_slv_regs: I2C target with a DEPTH x 8 register file.
// Header byte (7-bit address + R/W), then for writes a pointer byte followed
// by data bytes; reads stream regs[ptr] onward. The pointer auto-increments
// and wraps at DEPTH; a repeated START keeps it, so write-pointer + Sr + read
// works. SDA is open-drain: sda_oe=1 pulls the line low.
// Optional macro I2C_SLV_GLITCH_FILT_EN adds a FILT_LEN-clk glitch filter on
// both lines (see i2c_line_filt).
// Ports:
//  clk      in  system clock (>= 16x SCL)
//  resetn   in  async active-low reset
//  scl_i    in  SCL line (async)
//  sda_i    in  SDA line (async)
//  sda_oe   out 1 = drive SDA low
//  wr_vld   out 1-clk pulse per register byte written from the bus
//  wr_addr  out register index of that write
//  wr_data  out byte written
//  busy     out high between accepted START and STOP
module i2c_slv_regs
    import i2c_slv_pkg::*;
#(
    parameter logic [6:0] SLV_ADDR = 7'h50,
    parameter int         DEPTH    = 16,
    parameter int         FILT_LEN = 3
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     sda_oe,
    output logic                     wr_vld,
    output logic [$clog2(DEPTH)-1:0] wr_addr,
    output logic [7:0]               wr_data,
    output logic                     busy
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic scl_s, sda_s, scl_q, sda_q;
    logic scl_rise, scl_fall, start_det, stop_det;

    i2c_line_filt #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk(clk), .resetn(resetn), .line_i(scl_i), .line_o(scl_s)
    );
    i2c_line_filt #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk(clk), .resetn(resetn), .line_i(sda_i), .line_o(sda_s)
    );

    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = bus_start(scl_q, scl_s, sda_q, sda_s);
    assign stop_det  = bus_stop(scl_q, scl_s, sda_q, sda_s);

    i2c_slv_st_t       state;
    logic [7:0]        sh;
    logic [3:0]        bcnt;
    logic [ADDR_W-1:0] ptr;
    // In ACK states: 0 = waiting for the fall that starts the ACK slot,
    // 1 = ACK being driven. In RD_ACK: 1 = master ACKed, reload on next fall.
    logic              phase;
    logic [7:0]        regs [DEPTH];
    logic [7:0]        byte_in;

    assign byte_in = {sh[6:0], sda_s};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            state   <= ST_IDLE;
            sh      <= '0;
            bcnt    <= '0;
            ptr     <= '0;
            phase   <= 1'b0;
            sda_oe  <= 1'b0;
            wr_vld  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            scl_q  <= scl_s;
            sda_q  <= sda_s;
            wr_vld <= 1'b0;
            if (start_det) begin
                // Any partial byte is dropped; ptr is kept for Sr reads.
                state  <= ST_ADDR;
                busy   <= 1'b1;
                sda_oe <= 1'b0;
                bcnt   <= '0;
                phase  <= 1'b0;
            end else if (stop_det) begin
                state  <= ST_IDLE;
                busy   <= 1'b0;
                sda_oe <= 1'b0;
                bcnt   <= '0;
                phase  <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR, ST_PTR, ST_WR: if (scl_rise) begin
                        sh   <= byte_in;
                        bcnt <= bcnt + 1'b1;
                        if (bcnt == 4'd7) begin
                            bcnt  <= '0;
                            phase <= 1'b0;
                            case (state)
                                ST_ADDR: state <= (byte_in[7:1] == SLV_ADDR && byte_in[7:1] != 7'd0)
                                                  ? ST_ADDR_ACK : ST_WAIT;
                                ST_PTR: begin
                                    ptr   <= byte_in[ADDR_W-1:0];
                                    state <= ST_PTR_ACK;
                                end
                                default: begin
                                    regs[ptr] <= byte_in;
                                    wr_vld    <= 1'b1;
                                    wr_addr   <= ptr;
                                    wr_data   <= byte_in;
                                    ptr       <= ptr + 1'b1;
                                    state     <= ST_WR_ACK;
                                end
                            endcase
                        end
                    end
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: if (scl_fall) begin
                        if (!phase) begin
                            sda_oe <= ~I2C_ACK;
                            phase  <= 1'b1;
                        end else begin
                            phase  <= 1'b0;
                            sda_oe <= 1'b0;
                            if (state == ST_ADDR_ACK && sh[0]) begin
                                // sh still holds the header; bit 0 is R/W
                                sh     <= regs[ptr];
                                sda_oe <= ~regs[ptr][7];
                                state  <= ST_RD;
                            end else begin
                                state <= (state == ST_ADDR_ACK) ? ST_PTR : ST_WR;
                            end
                        end
                    end
                    ST_RD: begin
                        // Master samples on rise; next bit goes out after the fall.
                        if (scl_rise) begin
                            bcnt <= bcnt + 1'b1;
                            sh   <= {sh[6:0], 1'b0};
                        end else if (scl_fall) begin
                            if (bcnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                bcnt   <= '0;
                                phase  <= 1'b0;
                                state  <= ST_RD_ACK;
                            end else begin
                                sda_oe <= ~sh[7];
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_s == I2C_NACK) begin
                                state <= ST_WAIT;
                            end else begin
                                ptr   <= ptr + 1'b1;
                                phase <= 1'b1;
                            end
                        end else if (scl_fall && phase) begin
                            phase  <= 1'b0;
                            sh     <= regs[ptr];
                            sda_oe <= ~regs[ptr][7];
                            state  <= ST_RD;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slv_regs.sv
`timescale 1ns/1ps
module tb_i2c_slv_regs;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int Q     = 8;   // clks per quarter SCL period

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          scl_m = 1'b1;
    logic          sda_m = 1'b1;
    logic          sda_line;
    logic          sda_oe, wr_vld, busy;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slv_regs #(.SLV_ADDR(7'h50), .DEPTH(DEPTH), .FILT_LEN(3)) dut (
        .clk(clk), .resetn(resetn), .scl_i(scl_m), .sda_i(sda_line),
        .sda_oe(sda_oe), .wr_vld(wr_vld), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy)
    );

    typedef struct {
        string       name;
        logic [11:0] val;
    } sb_t;

    sb_t exp_bus_q[$];
    sb_t obs_bus_q[$];
    sb_t exp_wr_q[$];
    int  tests = 0;
    int  fails = 0;
    int  oe_cnt = 0;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: bus observations and write strobes
    always @(negedge clk) begin
        sb_t o, e;
        if (sda_oe) oe_cnt++;
        if (obs_bus_q.size() > 0) begin
            o = obs_bus_q.pop_front();
            if (exp_bus_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL %s: unexpected bus item 0x%0h", o.name, o.val);
            end else begin
                e = exp_bus_q.pop_front();
                check(e.name, o.val, e.val);
            end
        end
        if (wr_vld) begin
            if (exp_wr_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL wr_unexp: got addr %0d data 0x%0h expected no write", wr_addr, wr_data);
            end else begin
                e = exp_wr_q.pop_front();
                check(e.name, {wr_addr, wr_data}, e.val);
            end
        end
    end

    task automatic qwait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put_bit(input logic b);
        qwait(Q); sda_m = b; qwait(Q); scl_m = 1'b1; qwait(2*Q); scl_m = 1'b0;
    endtask

    task automatic put_bit_glitch(input logic b);
        qwait(Q); sda_m = b; qwait(Q); scl_m = 1'b1; qwait(Q);
        scl_m = 1'b0; qwait(1); scl_m = 1'b1; qwait(Q-1); scl_m = 1'b0;
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; qwait(2*Q); scl_m = 1'b1; qwait(Q); b = sda_line; qwait(Q); scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        qwait(Q); sda_m = 1'b1; qwait(Q); scl_m = 1'b1; qwait(Q); sda_m = 1'b0; qwait(Q); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        qwait(Q); sda_m = 1'b0; qwait(Q); scl_m = 1'b1; qwait(Q); sda_m = 1'b1; qwait(Q);
    endtask

    task automatic send_byte(input string nm, input logic [7:0] b, input logic exp_ack);
        logic a;
        exp_bus_q.push_back('{nm, 12'(exp_ack)});
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        get_bit(a);
        obs_bus_q.push_back('{nm, 12'(a)});
    endtask

    task automatic recv_byte(input string nm, input logic [7:0] exp_b, input logic ack);
        logic [7:0] v;
        exp_bus_q.push_back('{nm, 12'(exp_b)});
        for (int i = 7; i >= 0; i--) get_bit(v[i]);
        obs_bus_q.push_back('{nm, 12'(v)});
        put_bit(ack);
    endtask

    task automatic exp_wr(input string nm, input logic [AW-1:0] a, input logic [7:0] d);
        exp_wr_q.push_back('{nm, {a, d}});
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        // Reset values
        qwait(4);
        check("rst_sda_oe", 12'(sda_oe), 12'd0);
        check("rst_wr_vld", 12'(wr_vld), 12'd0);
        check("rst_wr_addr", 12'(wr_addr), 12'd0);
        check("rst_wr_data", 12'(wr_data), 12'd0);
        check("rst_busy", 12'(busy), 12'd0);
        resetn = 1'b1;
        qwait(4);

        // Write ptr 3, A5, 5A
        i2c_start();
        send_byte("w1_hdr_ack", 8'hA0, 1'b0);
        check("w1_busy", 12'(busy), 12'd1);
        send_byte("w1_ptr_ack", 8'h03, 1'b0);
        exp_wr("w1_wr0", 4'd3, 8'hA5);
        send_byte("w1_d0_ack", 8'hA5, 1'b0);
        exp_wr("w1_wr1", 4'd4, 8'h5A);
        send_byte("w1_d1_ack", 8'h5A, 1'b0);
        i2c_stop();
        check("w1_idle", 12'(busy), 12'd0);

        // Ptr 3, Sr, read 2 bytes
        i2c_start();
        send_byte("r1_hdr_ack", 8'hA0, 1'b0);
        send_byte("r1_ptr_ack", 8'h03, 1'b0);
        i2c_start();
        send_byte("r1_rhdr_ack", 8'hA1, 1'b0);
        recv_byte("r1_d0", 8'hA5, 1'b0);
        recv_byte("r1_d1", 8'h5A, 1'b1);
        i2c_stop();
        check("r1_oe_rel", 12'(sda_oe), 12'd0);
        check("r1_idle", 12'(busy), 12'd0);

        // Wrong address and general call: NACK, never driven
        c0 = oe_cnt;
        i2c_start();
        send_byte("na_hdr_nack", 8'hA2, 1'b1);
        check("na_busy", 12'(busy), 12'd1);
        i2c_stop();
        check("na_idle", 12'(busy), 12'd0);
        i2c_start();
        send_byte("gc_hdr_nack", 8'h00, 1'b1);
        i2c_stop();
        check("na_no_oe", 12'(oe_cnt - c0), 12'd0);

        // Pointer wrap on write, then read back across the wrap
        i2c_start();
        send_byte("wp_hdr_ack", 8'hA0, 1'b0);
        send_byte("wp_ptr_ack", 8'h0F, 1'b0);
        exp_wr("wp_wr15", 4'd15, 8'h11);
        send_byte("wp_d0_ack", 8'h11, 1'b0);
        exp_wr("wp_wr0", 4'd0, 8'h22);
        send_byte("wp_d1_ack", 8'h22, 1'b0);
        i2c_stop();
        i2c_start();
        send_byte("wr_hdr_ack", 8'hA0, 1'b0);
        send_byte("wr_ptr_ack", 8'h0F, 1'b0);
        i2c_start();
        send_byte("wr_rhdr_ack", 8'hA1, 1'b0);
        recv_byte("wr_rd15", 8'h11, 1'b0);
        recv_byte("wr_rd0", 8'h22, 1'b1);
        i2c_stop();

        // START after 4 data bits: no write, ptr kept, new header accepted
        i2c_start();
        send_byte("mb_hdr_ack", 8'hA0, 1'b0);
        send_byte("mb_ptr_ack", 8'h05, 1'b0);
        exp_wr("mb_wr5", 4'd5, 8'hC3);
        send_byte("mb_d0_ack", 8'hC3, 1'b0);
        i2c_stop();
        i2c_start();
        send_byte("mb2_hdr_ack", 8'hA0, 1'b0);
        send_byte("mb2_ptr_ack", 8'h05, 1'b0);
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
        i2c_start();
        send_byte("mb2_rhdr_ack", 8'hA1, 1'b0);
        recv_byte("mb2_rd5", 8'hC3, 1'b1);
        i2c_stop();

`ifdef I2C_SLV_GLITCH_FILT_EN
        // 1-clk SCL low glitch inside a data bit must not add a bit
        begin
            logic       a;
            logic [7:0] gb;
            gb = 8'h96;
            i2c_start();
            send_byte("gl_hdr_ack", 8'hA0, 1'b0);
            send_byte("gl_ptr_ack", 8'h07, 1'b0);
            exp_wr("gl_wr7", 4'd7, 8'h96);
            exp_bus_q.push_back('{"gl_d0_ack", 12'd0});
            for (int i = 7; i >= 0; i--) begin
                if (i == 3) put_bit_glitch(gb[i]);
                else        put_bit(gb[i]);
            end
            get_bit(a);
            obs_bus_q.push_back('{"gl_d0_ack", 12'(a)});
            i2c_stop();
        end
`endif

        // Reset during a read: SDA released at once, registers cleared
        i2c_start();
        send_byte("rr_hdr_ack", 8'hA0, 1'b0);
        send_byte("rr_ptr_ack", 8'h00, 1'b0);
        i2c_start();
        send_byte("rr_rhdr_ack", 8'hA1, 1'b0);
        qwait(Q);
        check("rr_drive_b7", 12'(sda_oe), 12'd1);   // regs[0]=0x22, bit7=0
        resetn = 1'b0;
        #1;
        check("rr_async_oe", 12'(sda_oe), 12'd0);
        check("rr_async_busy", 12'(busy), 12'd0);
        qwait(4);
        resetn = 1'b1;
        i2c_stop();
        i2c_start();
        send_byte("rc_hdr_ack", 8'hA0, 1'b0);
        send_byte("rc_ptr_ack", 8'h03, 1'b0);
        i2c_start();
        send_byte("rc_rhdr_ack", 8'hA1, 1'b0);
        recv_byte("rc_rd3", 8'h00, 1'b1);
        i2c_stop();

        qwait(50);
        check("sb_bus_drain", 12'(exp_bus_q.size()), 12'd0);
        check("sb_wr_drain", 12'(exp_wr_q.size()), 12'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
